stream_fifo: RTL and testbench

- Parametrised synchronous FIFO with valid/ready handshakes on both ports. Replaces the fixed single-mode FIFO.
- Adds:
  - arbitrary (non-power-of-2) depth
  - first-word-fall-through read port
  - occupancy count and programmable almost-full/almost-empty flags
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between stream producers and consumers in the accelerator datapath, single clock domain.

---
 rtl/stream_fifo.sv | 113 +++++++++++
 tb/tb_stream_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock FIFO with valid/ready handshakes on both ports.
// The depth can be any integer of 2 or more, and the pointers wrap explicitly.
// The read port is first-word-fall-through: the head entry is always visible
// on data_out while r_valid is high.
// All flags are decoded from the occupancy register alone.
// overflow and underflow are sticky error bits, cleared only by reset or flush.
module stream_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 3,
   parameter int AFULL_TH  = DEPTH - 1,
   parameter int AEMPTY_TH = 1,
   localparam int LW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             w_valid,
   output logic             w_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             r_valid,
   input  logic             r_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [LW-1:0]    level,
   output logic             overflow,
   output logic             underflow
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;
   logic [LW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             push, pop;

   assign fifo_full    = (level_q == FULL_LVL);
   assign fifo_empty   = (level_q == '0);
   assign almost_full  = (level_q >= LW'(AFULL_TH));
   assign almost_empty = (level_q <= LW'(AEMPTY_TH));
   assign w_ready      = !fifo_full;
   assign r_valid      = !fifo_empty;
   assign level        = level_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign data_out     = mem_q[rp_q];

   // A push or pop happens only when both sides of that port's handshake agree.
   assign push = w_valid & w_ready;
   assign pop  = r_valid & r_ready;

   // Next-state logic: advance the pointers, track occupancy, and latch errors. Flush overrides all of it.
   always_comb begin
      // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
      wp_d    = wp_q;
      rp_d    = rp_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;

      if (push) wp_d = (wp_q == LAST_IDX) ? '0 : wp_q + PW'(1);
      if (pop)  rp_d = (rp_q == LAST_IDX) ? '0 : rp_q + PW'(1);

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (w_valid && fifo_full)  ovf_d = 1'b1;
      if (r_ready && fifo_empty) udf_d = 1'b1;

      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         level_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end
   end

   // Control state register. The synchronous active-low reset takes priority over flush.
   always_ff @(posedge clk) begin
      // NOTE: state registers take non-blocking assignments, so every register samples pre-edge values.
      if (!reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage write. A push is discarded in any cycle where reset or flush is active.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; occupancy alone decides which entries are valid.
      if (reset && !flush && push) mem_q[wp_q] <= data_in;
   end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed table-driven checks on a depth-3 FIFO.
// Random traffic runs against queue-based reference models for depths 2, 3, 5 and 8.
module tb_stream_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- directed instance: WIDTH=8, DEPTH=3, AFULL_TH=2, AEMPTY_TH=1
   logic       reset, flush, w_valid, r_ready;
   logic [7:0] data_in, data_out;
   logic       w_ready, r_valid, fifo_full, fifo_empty, almost_full, almost_empty;
   logic       overflow, underflow;
   logic [1:0] level;

   stream_fifo #(.WIDTH(8), .DEPTH(3)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .w_valid(w_valid), .w_ready(w_ready), .data_in(data_in),
      .r_valid(r_valid), .r_ready(r_ready), .data_out(data_out),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .level(level), .overflow(overflow), .underflow(underflow)
   );

   typedef struct {
      logic       fl;
      logic       wv;
      logic [7:0] din;
      logic       rr;
      int         lvl;
      logic       ovf;
      logic       udf;
      logic       dchk;
      logic [7:0] dout;
   } vec_t;

   // Expected flags for a given occupancy: {full, empty, afull, aempty, w_ready, r_valid}.
   function automatic logic [5:0] dir_flags(input int l);
      return {l == 3, l == 0, l >= 2, l <= 1, l != 3, l != 0};
   endfunction

   task automatic check_state(input string nm, input int lvl, input logic ovf, input logic udf,
                              input logic dchk, input logic [7:0] dout);
      check({nm, "_level"}, 64'(level), 64'(lvl));
      check({nm, "_flags"}, {fifo_full, fifo_empty, almost_full, almost_empty, w_ready, r_valid},
            dir_flags(lvl));
      check({nm, "_err"}, {overflow, underflow}, {ovf, udf});
      if (dchk) check({nm, "_dout"}, data_out, dout);
   endtask

   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      flush = v.fl; w_valid = v.wv; data_in = v.din; r_ready = v.rr;
      @(posedge clk);
      #1;
      check_state(nm, v.lvl, v.ovf, v.udf, v.dchk, v.dout);
   endtask

   task automatic idle();
      @(negedge clk);
      flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0; data_in = '0;
   endtask

   // ---------------- random instances, each with its own queue model
   for (genvar g = 0; g < 4; g++) begin : gen_rand
      localparam int D = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 5 : 8;
      logic                     g_rst, g_fl, g_wv, g_rr;
      logic [15:0]              g_din, g_dout;
      logic                     g_wr, g_rv, g_full, g_empty, g_af, g_ae, g_ovf, g_udf;
      logic [$clog2(D+1)-1:0]   g_lvl;
      logic                     done = 1'b0;

      stream_fifo #(.WIDTH(16), .DEPTH(D)) u_rdut (
         .clk(clk), .reset(g_rst), .flush(g_fl),
         .w_valid(g_wv), .w_ready(g_wr), .data_in(g_din),
         .r_valid(g_rv), .r_ready(g_rr), .data_out(g_dout),
         .fifo_full(g_full), .fifo_empty(g_empty),
         .almost_full(g_af), .almost_empty(g_ae),
         .level(g_lvl), .overflow(g_ovf), .underflow(g_udf)
      );

      initial begin
         logic [15:0] q[$];
         bit          m_ovf, m_udf;
         int          sz, wbias, rbias;
         string       pfx;
         pfx   = $sformatf("rand_d%0d", D);
         m_ovf = 1'b0;
         m_udf = 1'b0;
         wbias = 50;
         rbias = 50;
         g_rst = 1'b0; g_fl = 1'b0; g_wv = 1'b0; g_rr = 1'b0; g_din = '0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         g_rst = 1'b1;
         for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            sz = q.size();
            check({pfx, "_level"}, 64'(g_lvl), 64'(sz));
            check({pfx, "_flags"}, {g_full, g_empty, g_af, g_ae, g_wr, g_rv},
                  {sz == D, sz == 0, sz >= D - 1, sz <= 1, sz != D, sz != 0});
            check({pfx, "_err"}, {g_ovf, g_udf}, {m_ovf, m_udf});
            if (sz > 0) check({pfx, "_dout"}, g_dout, q[0]);
            if (cyc % 256 == 0) begin
               wbias = $urandom_range(10, 90);
               rbias = $urandom_range(10, 90);
            end
            g_wv  = ($urandom_range(0, 99) < wbias);
            g_rr  = ($urandom_range(0, 99) < rbias);
            g_fl  = ($urandom_range(0, 299) == 0);
            g_din = 16'($urandom);
            @(posedge clk);
            if (g_fl) begin
               q.delete();
               m_ovf = 1'b0;
               m_udf = 1'b0;
            end else begin
               if (g_wv && sz == D) m_ovf = 1'b1;
               if (g_rr && sz == 0) m_udf = 1'b1;
               if (g_rr && sz > 0) void'(q.pop_front());
               if (g_wv && sz < D) q.push_back(g_din);
            end
         end
         done = 1'b1;
      end
   end

   // ---------------- directed sequence
   initial begin
      vec_t vecs[$];
      reset = 1'b0; flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0; data_in = '0;

      // Reset held for five cycles with no traffic.
      repeat (5) begin
         @(posedge clk);
         #1;
         check_state("reset_hold", 0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_state("reset_release", 0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Each record: inputs for one edge, then the expected state after that edge.
      //                    fl wv din    rr  lvl ovf udf dchk dout
      vecs.push_back(vec_t'{0, 1, 8'hA0, 0,  1,  0,  0,  1,  8'hA0}); // fill
      vecs.push_back(vec_t'{0, 1, 8'hA1, 0,  2,  0,  0,  1,  8'hA0});
      vecs.push_back(vec_t'{0, 1, 8'hA2, 0,  3,  0,  0,  1,  8'hA0});
      vecs.push_back(vec_t'{0, 1, 8'hA3, 0,  3,  1,  0,  1,  8'hA0}); // overflow, A3 dropped
      vecs.push_back(vec_t'{0, 0, 8'h00, 1,  2,  1,  0,  1,  8'hA1}); // drain
      vecs.push_back(vec_t'{0, 0, 8'h00, 1,  1,  1,  0,  1,  8'hA2});
      vecs.push_back(vec_t'{0, 0, 8'h00, 1,  0,  1,  0,  0,  8'h00});
      vecs.push_back(vec_t'{0, 1, 8'hB0, 0,  1,  1,  0,  1,  8'hB0}); // wrap with streaming
      vecs.push_back(vec_t'{0, 1, 8'hB1, 1,  1,  1,  0,  1,  8'hB1});
      vecs.push_back(vec_t'{0, 1, 8'hB2, 1,  1,  1,  0,  1,  8'hB2});
      vecs.push_back(vec_t'{0, 1, 8'hB3, 1,  1,  1,  0,  1,  8'hB3});
      vecs.push_back(vec_t'{0, 1, 8'hB4, 1,  1,  1,  0,  1,  8'hB4});
      vecs.push_back(vec_t'{0, 0, 8'h00, 1,  0,  1,  0,  0,  8'h00});
      vecs.push_back(vec_t'{0, 1, 8'hD0, 0,  1,  1,  0,  1,  8'hD0}); // full + pop
      vecs.push_back(vec_t'{0, 1, 8'hD1, 0,  2,  1,  0,  1,  8'hD0});
      vecs.push_back(vec_t'{0, 1, 8'hD2, 0,  3,  1,  0,  1,  8'hD0});
      vecs.push_back(vec_t'{0, 1, 8'hD3, 1,  2,  1,  0,  1,  8'hD1}); // pop only, D3 dropped
      vecs.push_back(vec_t'{0, 1, 8'hD4, 1,  2,  1,  0,  1,  8'hD2}); // push + pop
      vecs.push_back(vec_t'{0, 0, 8'h00, 1,  1,  1,  0,  1,  8'hD4});
      vecs.push_back(vec_t'{0, 1, 8'hE0, 0,  2,  1,  0,  1,  8'hD4}); // flush priority
      vecs.push_back(vec_t'{1, 1, 8'hE1, 1,  0,  0,  0,  0,  8'h00});
      vecs.push_back(vec_t'{0, 1, 8'hC0, 0,  1,  0,  0,  1,  8'hC0});
      vecs.push_back(vec_t'{0, 0, 8'h00, 1,  0,  0,  0,  0,  8'h00});
      vecs.push_back(vec_t'{0, 0, 8'h00, 1,  0,  0,  1,  0,  8'h00}); // underflow
      vecs.push_back(vec_t'{1, 0, 8'h00, 0,  0,  0,  0,  0,  8'h00}); // flush clears it

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));
      idle();

      // Reset mid-operation discards contents and beats a simultaneous flush and push.
      apply(vec_t'{0, 1, 8'hF0, 0, 1, 0, 0, 1, 8'hF0}, "midrst_fill0");
      apply(vec_t'{0, 1, 8'hF1, 0, 2, 0, 0, 1, 8'hF0}, "midrst_fill1");
      @(negedge clk);
      reset = 1'b0; flush = 1'b1; w_valid = 1'b1; data_in = 8'hF2; r_ready = 1'b1;
      @(posedge clk);
      #1;
      check_state("midrst_active", 0, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      reset = 1'b1; flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
      @(posedge clk);
      #1;
      check_state("midrst_release", 0, 1'b0, 1'b0, 1'b0, 8'h00);
      apply(vec_t'{0, 1, 8'hF3, 0, 1, 0, 0, 1, 8'hF3}, "midrst_first");
      idle();

      // Wait, with a bound, for the random runs to finish.
      for (int cyc = 0; cyc < 30000; cyc++) begin
         if (gen_rand[0].done && gen_rand[1].done && gen_rand[2].done && gen_rand[3].done) break;
         @(posedge clk);
      end
      check("random_done",
            {gen_rand[0].done, gen_rand[1].done, gen_rand[2].done, gen_rand[3].done}, 4'b1111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
